bf_prog_mem: RTL and testbench



---
 rtl/bf_pkg.sv | 32 +++
 rtl/bf_bracket_stack.sv | 29 ++
 rtl/bf_prog_mem.sv | 110 +++++++++++
 tb/tb_bf_prog_mem.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// bf_pkg: brainfuck opcode encoding, load FSM states, terminator bytes and the ASCII command decoder
package bf_pkg;
  typedef enum logic [2:0] {
    OP_IN   = 3'b000,
    OP_OUT  = 3'b001,
    OP_BACK = 3'b010,
    OP_IF   = 3'b011,
    OP_MOVL = 3'b100,
    OP_MOVR = 3'b101,
    OP_DEC  = 3'b110,
    OP_INC  = 3'b111
  } opcode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;
  typedef struct packed {
    logic    is_cmd;
    opcode_t op;
  } dec_t;
  localparam logic [7:0] TERM_BANG = 8'h21;
  localparam logic [7:0] TERM_NUL  = 8'h00;
  function automatic dec_t bf_decode(input logic [7:0] c);
    dec_t d;
    d.is_cmd = c inside {8'h2B, 8'h2D, 8'h3E, 8'h3C, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
    d.op = c == 8'h2B ? OP_INC  :
           c == 8'h2D ? OP_DEC  :
           c == 8'h3E ? OP_MOVR :
           c == 8'h3C ? OP_MOVL :
           c == 8'h5B ? OP_IF   :
           c == 8'h5D ? OP_BACK :
           c == 8'h2E ? OP_OUT  : OP_IN;
    return d;
  endfunction
endpackage

// File: rtl/bf_bracket_stack.sv
// bf_bracket_stack: LIFO of bracket addresses (clk, rst, clr, push/pop, din, top, full, empty)
module bf_bracket_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  cnt;
  assign empty = cnt == '0;
  assign full  = cnt == (PW+1)'(DEPTH);
  assign top   = mem[cnt[PW-1:0] - PW'(1)];
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (push && !full) cnt <= cnt + (PW+1)'(1);
    else if (pop && !empty) cnt <= cnt - (PW+1)'(1);
  end
  always_ff @(posedge clk)
    if (push && !full && !clr) mem[cnt[PW-1:0]] <= din;
endmodule

// File: rtl/bf_prog_mem.sv
// bf_prog_mem: writable brainfuck program store; ld_* byte loader, fetch_* 1-cycle read port, optional jump table with BF_JUMP_TABLE_EN
module bf_prog_mem
  import bf_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              loading,
  output logic              load_err,
  output logic [ADDR_W:0]   prog_len,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [2:0]        fetch_code,
  output logic [ADDR_W-1:0] fetch_jump,
  output logic              rom_overrun
);
  localparam int DEPTH = 1 << ADDR_W;
  state_t            state;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W-1:0] wa;
  logic [2:0]        mem [DEPTH];
  logic [2:0]        code_q;
  logic [ADDR_W-1:0] addr_q;
  dec_t              dec;
  logic              acc, term, wr_en, ovf, br_err, end_err;
  assign dec         = bf_decode(ld_data);
  assign wa          = wr_ptr[ADDR_W-1:0];
  assign acc         = state == ST_LOAD && ld_valid && ld_ready;
  assign term        = ld_data == TERM_BANG || ld_data == TERM_NUL;
  assign wr_en       = acc && dec.is_cmd && !wr_ptr[ADDR_W];
  assign ovf         = acc && dec.is_cmd && wr_ptr[ADDR_W];
  assign rom_overrun = state != ST_RUN || {1'b0, addr_q} >= prog_len;
  assign fetch_code  = rom_overrun ? OP_INC : code_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ld_ready <= 1'b0;
      loading  <= 1'b0;
      load_err <= 1'b0;
      prog_len <= '0;
      wr_ptr   <= '0;
    end else if (load_start) begin
      state    <= ST_LOAD;
      ld_ready <= 1'b1;
      loading  <= 1'b1;
      load_err <= 1'b0;
      prog_len <= '0;
      wr_ptr   <= '0;
    end else if (acc && term) begin
      state    <= ST_RUN;
      ld_ready <= 1'b0;
      loading  <= 1'b0;
      load_err <= load_err | end_err;
      prog_len <= wr_ptr;
    end else if (ovf) begin
      state    <= ST_RUN;
      ld_ready <= 1'b0;
      loading  <= 1'b0;
      load_err <= 1'b1;
      prog_len <= (ADDR_W+1)'(DEPTH);
    end else if (wr_en) begin
      wr_ptr   <= wr_ptr + (ADDR_W+1)'(1);
      load_err <= load_err | br_err;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wa] <= dec.op;
    code_q <= mem[fetch_addr];
    addr_q <= fetch_addr;
  end
`ifdef BF_JUMP_TABLE_EN
  logic [ADDR_W-1:0] jmem [DEPTH];
  logic [ADDR_W-1:0] jump_q, top;
  logic              full, empty, push, pop;
  assign push    = wr_en && dec.op == OP_IF && !full;
  assign pop     = wr_en && dec.op == OP_BACK && !empty;
  assign br_err  = wr_en && ((dec.op == OP_IF && full) || (dec.op == OP_BACK && empty));
  assign end_err = !empty;
  bf_bracket_stack #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (load_start),
    .push  (push),
    .pop   (pop),
    .din   (wa),
    .top   (top),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk) begin
    if (pop) begin
      jmem[top] <= wa;
      jmem[wa]  <= top;
    end
    jump_q <= jmem[fetch_addr];
  end
  assign fetch_jump = rom_overrun ? '0 : jump_q;
`else
  logic unused_stack_depth;
  assign unused_stack_depth = |STACK_DEPTH;
  assign br_err     = 1'b0;
  assign end_err    = 1'b0;
  assign fetch_jump = '0;
`endif
endmodule

// File: tb/tb_bf_prog_mem.sv
// tb_bf_prog_mem: directed self-checking bench for bf_prog_mem (default size and ADDR_W=2 instance)
module tb_bf_prog_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ls0 = 1'b0, ls1 = 1'b0, lv = 1'b0, sel = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic [9:0]  fa0 = '0;
  logic [1:0]  fa1 = '0;
  logic        rdy0, rdy1, ldg0, ldg1, err0, err1, ovr0, ovr1;
  logic [10:0] plen0;
  logic [2:0]  plen1;
  logic [2:0]  code0, code1;
  logic [9:0]  jump0;
  logic [1:0]  jump1;
  logic        lv0, lv1;
  int          checks = 0, failures = 0;
  assign lv0 = lv && !sel;
  assign lv1 = lv && sel;
  always #5 clk = ~clk;
  bf_prog_mem u0 (
    .clk(clk), .rst(rst), .load_start(ls0), .ld_valid(lv0), .ld_data(ld_data),
    .ld_ready(rdy0), .loading(ldg0), .load_err(err0), .prog_len(plen0),
    .fetch_addr(fa0), .fetch_code(code0), .fetch_jump(jump0), .rom_overrun(ovr0)
  );
  bf_prog_mem #(.ADDR_W(2)) u1 (
    .clk(clk), .rst(rst), .load_start(ls1), .ld_valid(lv1), .ld_data(ld_data),
    .ld_ready(rdy1), .loading(ldg1), .load_err(err1), .prog_len(plen1),
    .fetch_addr(fa1), .fetch_code(code1), .fetch_jump(jump1), .rom_overrun(ovr1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start();
    if (sel) ls1 = 1'b1; else ls0 = 1'b1;
    @(negedge clk);
    ls0 = 1'b0;
    ls1 = 1'b0;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!(sel ? rdy1 : rdy0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ld_ready_wait", 32'(sel ? rdy1 : rdy0), 1);
    ld_data = b;
    lv = 1'b1;
    @(negedge clk);
    lv = 1'b0;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask
  task automatic fetch0(input int a, input logic [2:0] code, input logic ovr);
    fa0 = 10'(a);
    @(negedge clk);
    chk($sformatf("code0@%0d", a), 32'(code0), 32'(code));
    chk($sformatf("ovr0@%0d", a), 32'(ovr0), 32'(ovr));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy0), 0);
    chk("rst_loading", 32'(ldg0), 0);
    chk("rst_err", 32'(err0), 0);
    chk("rst_len", 32'(plen0), 0);
    chk("rst_code", 32'(code0), 7);
    chk("rst_jump", 32'(jump0), 0);
    chk("rst_ovr", 32'(ovr0), 1);
    rst = 1'b0;
    @(negedge clk);
    start();
    chk("load_ready", 32'(rdy0), 1);
    chk("load_loading", 32'(ldg0), 1);
    chk("load_ovr", 32'(ovr0), 1);
    send_str("+[-].!");
    chk("p1_len", 32'(plen0), 5);
    chk("p1_loading", 32'(ldg0), 0);
    chk("p1_err", 32'(err0), 0);
    fetch0(0, 3'b111, 0);
    fetch0(1, 3'b011, 0);
    fetch0(2, 3'b110, 0);
    fetch0(3, 3'b010, 0);
    fetch0(4, 3'b001, 0);
    fetch0(5, 3'b111, 1);
    start();
    send_str("a+ b\n-");
    send(8'h00);
    chk("p2_len", 32'(plen0), 2);
    chk("p2_err", 32'(err0), 0);
    fetch0(0, 3'b111, 0);
    fetch0(1, 3'b110, 0);
    fetch0(2, 3'b111, 1);
    sel = 1'b1;
    start();
    send_str("+++++");
    chk("ovf_err", 32'(err1), 1);
    chk("ovf_len", 32'(plen1), 4);
    chk("ovf_loading", 32'(ldg1), 0);
    chk("ovf_ready", 32'(rdy1), 0);
    fa1 = 2'd3;
    @(negedge clk);
    chk("ovf_code3", 32'(code1), 7);
    chk("ovf_ovr3", 32'(ovr1), 0);
    sel = 1'b0;
    start();
    send_str("+-+");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_loading", 32'(ldg0), 0);
    chk("abort_len", 32'(plen0), 0);
    chk("abort_ovr", 32'(ovr0), 1);
    start();
    send_str("+!");
    chk("reload_len", 32'(plen0), 1);
    fetch0(0, 3'b111, 0);
    start();
    chk("restart_ovr", 32'(ovr0), 1);
    send("-");
    chk("restart_ovr_mid", 32'(ovr0), 1);
    chk("restart_code_mid", 32'(code0), 7);
    send("!");
    chk("restart_ovr_end", 32'(ovr0), 0);
    chk("restart_code_end", 32'(code0), 6);
`ifdef BF_JUMP_TABLE_EN
    start();
    send_str("[[]]!");
    chk("jt_err", 32'(err0), 0);
    chk("jt_len", 32'(plen0), 4);
    for (int a = 0; a < 4; a++) begin
      fa0 = 10'(a);
      @(negedge clk);
      chk($sformatf("jump@%0d", a), 32'(jump0), 32'(3 - a));
    end
    start();
    send_str("]!");
    chk("jt_unmatched_err", 32'(err0), 1);
    start();
    send_str("[!");
    chk("jt_open_err", 32'(err0), 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
